// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with 50% duty cycle for both even and odd divisors.
// Define CLK_DIV_GATE_EN to add the clk_en input that mutes output periods at wrap edges.
module clk_div_prog #(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned DIV_INIT = 9
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLK_DIV_GATE_EN
    input  logic             clk_en,
`endif
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             div_busy,
    output logic             div_err,
    output logic [DIV_W-1:0] cur_div
);

    localparam logic [DIV_W-1:0] INIT_DIV = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] INIT_CNT = DIV_W'(DIV_INIT - 1);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] r_cur;
    logic             r_p;
    logic             r_n;
    logic             r_busy;
    logic             r_err;

    logic [DIV_W-1:0] w_last;
    logic [DIV_W-1:0] w_cnt_d;
    logic [DIV_W-1:0] w_cur_d;
    logic [DIV_W-1:0] w_pend_d;
    logic [DIV_W-1:0] w_half;
    logic             w_wrap;
    logic             w_run;
    logic             w_gate_d;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_busy_d;
    logic             w_p_d;

`ifdef CLK_DIV_GATE_EN
    logic             r_gate;
    logic [DIV_W-1:0] r_idle;
    logic [DIV_W-1:0] w_idle_d;
`endif

    always_comb begin
        w_load_ok  = div_load && (div_val >= MIN_DIV);
        w_load_bad = div_load && (div_val < MIN_DIV);
        w_last     = r_cur - 1'b1;

`ifdef CLK_DIV_GATE_EN
        // While muted, cnt parks at 0 and r_idle times the silent period instead.
        w_run    = clk_en;
        w_wrap   = r_gate ? (r_idle == w_last) : (r_cnt == w_last);
        w_gate_d = w_wrap ? ~clk_en : r_gate;
        w_idle_d = (r_gate && !w_wrap) ? r_idle + 1'b1 : '0;
`else
        w_run    = 1'b1;
        w_wrap   = (r_cnt == w_last);
        w_gate_d = 1'b0;
`endif

        // Pending value registered before this edge is applied; a load at this edge waits.
        w_cur_d = (w_wrap && w_run && r_busy) ? r_pend : r_cur;

        if (w_wrap || w_gate_d) begin
            w_cnt_d = '0;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end

        w_pend_d = w_load_ok ? div_val : r_pend;

        if (w_load_ok) begin
            w_busy_d = 1'b1;
        end else if (w_wrap && w_run) begin
            w_busy_d = 1'b0;
        end else begin
            w_busy_d = r_busy;
        end

        // High phase length H = ceil(N/2), computed without overflow at N = 2^DIV_W-1.
        w_half = (w_cur_d >> 1) + DIV_W'(w_cur_d[0]);
        w_p_d  = !w_gate_d && (w_cnt_d < w_half);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= INIT_CNT;
            r_p    <= 1'b0;
            r_pend <= INIT_DIV;
            r_cur  <= INIT_DIV;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_d;
            r_p    <= w_p_d;
            r_pend <= w_pend_d;
            r_cur  <= w_cur_d;
            r_busy <= w_busy_d;
            r_err  <= w_load_bad;
        end
    end

`ifdef CLK_DIV_GATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gate <= 1'b0;
            r_idle <= '0;
        end else begin
            r_gate <= w_gate_d;
            r_idle <= w_idle_d;
        end
    end
`endif

    // Half-cycle delayed copy; ANDing with r_p trims half a clock off the odd high phase.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_n <= 1'b0;
        end else begin
            r_n <= r_p;
        end
    end

    assign clk_out  = r_cur[0] ? (r_p & r_n) : r_p;
    assign div_busy = r_busy;
    assign div_err  = r_err;
    assign cur_div  = r_cur;

endmodule
